// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//
// Two-stage pipelined barrel shifter with valid/ready handshakes on both
// sides. Stage S1 applies the low part of the shift amount and computes the
// carry; stage S2 applies the high part and registers the result, the zero flag
// and the tag straight onto the out_* ports.
//
// Operations (in_op):
//   2'b00 SLL  logical left, zero fill
//   2'b01 SRL  logical right, zero fill
//   2'b10 SRA  arithmetic right, fill with the operand's original MSB
//   2'b11 ROL  rotate left
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset; empties both stages
//   in_valid   request presented
//   in_ready   request accepted this cycle (combinational, no in_valid path)
//   in_data    operand, WIDTH bits
//   in_shamt   shift amount, 0..WIDTH-1
//   in_op      operation select
//   in_tag     opaque tag carried alongside the request
//   out_valid  result presented
//   out_ready  consumer accepts the result
//   out_data   shift result
//   out_carry  last bit shifted out (0 for ROL and for a shift of 0)
//   out_zero   out_data == 0, registered together with out_data
//   out_tag    tag belonging to this result
//
// Handshake: a transfer happens on a rising edge where valid && ready on that
// port. The producer holds its payload while valid is high and ready is low;
// this block holds out_* stable while out_valid && !out_ready, and in_ready
// never depends on in_valid.
// -----------------------------------------------------------------------------
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shamt,
  input  logic [1:0]                 in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int LO_W = SH_W / 2;
  localparam int HI_W = SH_W - LO_W;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;   // operand after the low-part shift
  logic [HI_W-1:0]  s1_hi;     // high part of the shift amount, used in S2
  logic [1:0]       s1_op;
  logic             s1_fill;   // fill bit for right shifts in S2
  logic             s1_carry;
  logic [TAG_W-1:0] s1_tag;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s2_advance;
  logic s1_load;

  // S2 takes a new result when S1 has one and the output slot is free or
  // being emptied this cycle.
  assign s2_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s2_advance;
  assign s1_load    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 datapath: shift by in_shamt[LO_W-1:0], carry from the full amount
  // ---------------------------------------------------------------------------
  logic [LO_W-1:0]    lo_amt;
  logic [HI_W-1:0]    hi_amt;
  logic               s1_fill_next;
  logic [2*WIDTH-1:0] s1_rol_wide;
  logic [2*WIDTH-1:0] s1_right_wide;
  logic [WIDTH-1:0]   s1_data_next;
  logic               s1_carry_next;

  assign lo_amt = in_shamt[LO_W-1:0];
  assign hi_amt = in_shamt[SH_W-1:LO_W];

  // Only SRA fills with the sign; the bit is kept for S2 so that the original
  // operand's MSB drives the fill through both stages.
  assign s1_fill_next = (in_op == OP_SRA) && in_data[WIDTH-1];

  always_comb begin
    s1_rol_wide   = {in_data, in_data} << lo_amt;
    s1_right_wide = {{WIDTH{s1_fill_next}}, in_data} >> lo_amt;
    s1_data_next  = in_data;
    case (in_op)
      OP_SLL:  s1_data_next = in_data << lo_amt;
      OP_SRL:  s1_data_next = s1_right_wide[WIDTH-1:0];
      OP_SRA:  s1_data_next = s1_right_wide[WIDTH-1:0];
      OP_ROL:  s1_data_next = s1_rol_wide[2*WIDTH-1:WIDTH];
      default: s1_data_next = in_data;
    endcase
  end

  // Carry is the last bit that leaves the word for the whole shift amount:
  // in_data[WIDTH-n] for a left shift, in_data[n-1] for a right shift.
  always_comb begin
    s1_carry_next = 1'b0;
    if (in_shamt != '0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((in_op == OP_SLL) && (i == WIDTH - int'(in_shamt)))
          s1_carry_next = in_data[i];
        else if (((in_op == OP_SRL) || (in_op == OP_SRA)) &&
                 (i == int'(in_shamt) - 1))
          s1_carry_next = in_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_hi    <= '0;
      s1_op    <= OP_SLL;
      s1_fill  <= 1'b0;
      s1_carry <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= s1_data_next;
        s1_hi    <= hi_amt;
        s1_op    <= in_op;
        s1_fill  <= s1_fill_next;
        s1_carry <= s1_carry_next;
        s1_tag   <= in_tag;
      end else if (s2_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: shift by the high part, scaled by 2**LO_W
  // ---------------------------------------------------------------------------
  logic [SH_W-1:0]    s2_amt;
  logic [2*WIDTH-1:0] s2_rol_wide;
  logic [2*WIDTH-1:0] s2_right_wide;
  logic [WIDTH-1:0]   s2_data_next;

  assign s2_amt = {s1_hi, {LO_W{1'b0}}};

  always_comb begin
    s2_rol_wide   = {s1_data, s1_data} << s2_amt;
    s2_right_wide = {{WIDTH{s1_fill}}, s1_data} >> s2_amt;
    s2_data_next  = s1_data;
    case (s1_op)
      OP_SLL:  s2_data_next = s1_data << s2_amt;
      OP_SRL:  s2_data_next = s2_right_wide[WIDTH-1:0];
      OP_SRA:  s2_data_next = s2_right_wide[WIDTH-1:0];
      OP_ROL:  s2_data_next = s2_rol_wide[2*WIDTH-1:WIDTH];
      default: s2_data_next = s1_data;
    endcase
  end

  // Output registers only change on s2_advance, which keeps them stable while
  // the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s2_advance) begin
        out_valid <= 1'b1;
        out_data  <= s2_data_next;
        out_carry <= s1_carry;
        out_zero  <= (s2_data_next == '0);
        out_tag   <= s1_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
//
// Directed scenarios on a WIDTH=32 instance plus randomized traffic on
// WIDTH=8, 32 and 64 instances. Expected results come from a bit-by-bit
// reference function and are queued at acceptance; monitors compare the head
// of the queue against the outputs on every cycle out_valid is high and pop
// it when out_ready completes the transfer.
// -----------------------------------------------------------------------------
module tb_shift_pipe;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic d_rst_n;
  logic r_rst_n;

  int n_pass  = 0;
  int n_total = 0;
  bit run_rnd = 1'b0;
  int rnd_done_cnt = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: result bit i is chosen straight from the operation's
  // definition. Returns {carry, data}.
  function automatic logic [64:0] ref_shift(input int w, input logic [63:0] d,
                                            input int n, input logic [1:0] op);
    logic [63:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'd0:    r[i] = (i >= n) ? d[i-n] : 1'b0;
        2'd1:    r[i] = (i + n < w) ? d[i+n] : 1'b0;
        2'd2:    r[i] = (i + n < w) ? d[i+n] : d[w-1];
        default: r[i] = d[(i - n + w) % w];
      endcase
    end
    if (n > 0) begin
      if (op == 2'd0) c = d[w-n];
      else if (op == 2'd1 || op == 2'd2) c = d[n-1];
    end
    return {c, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Directed instance (WIDTH=32)
  // ---------------------------------------------------------------------------
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [31:0] d_in_data, d_out_data;
  logic [4:0]  d_in_shamt;
  logic [1:0]  d_in_op;
  logic [3:0]  d_in_tag, d_out_tag;
  logic        d_out_carry, d_out_zero;

  shift_pipe #(.WIDTH(32), .TAG_W(4)) dut_d (
    .clock(clock), .reset_n(d_rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .in_shamt(d_in_shamt), .in_op(d_in_op), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_carry(d_out_carry), .out_zero(d_out_zero), .out_tag(d_out_tag)
  );

  // {tag, zero, carry, data}
  logic [37:0] dq[$];
  int d_accepts = 0;

  always @(negedge clock) begin
    if (d_rst_n && d_out_valid) begin
      if (dq.size() == 0) check("d_spurious_valid", d_out_valid, 1'b0);
      else begin
        check("d_result", {d_out_tag, d_out_zero, d_out_carry, d_out_data}, dq[0]);
        if (d_out_ready) void'(dq.pop_front());
      end
    end
  end

  task automatic d_send(input logic [1:0] op, input logic [31:0] data,
                        input logic [4:0] sh, input logic [3:0] tag,
                        input logic [31:0] ed, input logic ec, output int waited);
    @(posedge clock); #1;
    d_in_valid = 1'b1; d_in_op = op; d_in_data = data;
    d_in_shamt = sh;   d_in_tag = tag;
    waited = 0;
    forever begin
      @(negedge clock);
      if (d_in_ready) begin
        dq.push_back({tag, (ed == 32'd0), ec, ed});
        d_accepts++;
        break;
      end
      waited++;
      if (waited > 50) begin
        check("d_accept_timeout", d_in_ready, 1'b1);
        break;
      end
    end
  endtask

  task automatic d_send_m(input logic [1:0] op, input logic [31:0] data,
                          input logic [4:0] sh, input logic [3:0] tag);
    logic [64:0] m;
    int w;
    m = ref_shift(32, {32'd0, data}, int'(sh), op);
    d_send(op, data, sh, tag, m[31:0], m[64], w);
  endtask

  task automatic d_idle();
    @(posedge clock); #1;
    d_in_valid = 1'b0;
  endtask

  task automatic d_drain();
    int k;
    k = 0;
    while (dq.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("d_drain_empty", dq.size(), 0);
  endtask

  // Accept edge N happens right after d_send returns; out_valid must be low
  // after N and high after N+1, so the result transfers on edge N+2.
  task automatic d_latency();
    d_idle();
    @(negedge clock);
    check("lat_not_early", d_out_valid, 1'b0);
    @(negedge clock);
    check("lat_at_two", d_out_valid, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Random instances (WIDTH = 8, 32, 64)
  // ---------------------------------------------------------------------------
  localparam int WS [3] = '{8, 32, 64};

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W  = WS[g];
    localparam int SW = $clog2(W);

    logic          rv, rr, ir, ov, oc, oz;
    logic [W-1:0]  rd, od;
    logic [SW-1:0] rs;
    logic [1:0]    rop;
    logic [3:0]    rt, ot;
    logic          acc = 1'b0;
    logic [W+5:0]  q[$];

    shift_pipe #(.WIDTH(W), .TAG_W(4)) dut (
      .clock(clock), .reset_n(r_rst_n),
      .in_valid(rv), .in_ready(ir), .in_data(rd), .in_shamt(rs),
      .in_op(rop), .in_tag(rt),
      .out_valid(ov), .out_ready(rr), .out_data(od),
      .out_carry(oc), .out_zero(oz), .out_tag(ot)
    );

    always @(negedge clock) begin
      logic [64:0] m;
      acc = 1'b0;
      if (r_rst_n) begin
        if (rv && ir) begin
          acc = 1'b1;
          m = ref_shift(W, 64'(rd), int'(rs), rop);
          q.push_back({rt, (m[W-1:0] == '0), m[64], m[W-1:0]});
        end
        if (ov) begin
          if (q.size() == 0) check($sformatf("w%0d_spurious_valid", W), ov, 1'b0);
          else begin
            check($sformatf("w%0d_result", W), {ot, oz, oc, od}, q[0]);
            if (rr) void'(q.pop_front());
          end
        end
      end
    end

    initial begin
      logic [63:0] t;
      int k, sel;
      rv = 1'b0; rr = 1'b1; rd = '0; rs = '0; rop = 2'd0; rt = 4'd0;
      wait (run_rnd);
      for (int c = 0; c < 600; c++) begin
        @(posedge clock); #1;
        // Payload only changes once the previous request was taken.
        if (!rv || acc) begin
          rv  = ($urandom_range(0, 3) != 0);
          t   = {$urandom, $urandom};
          rd  = t[W-1:0];
          rop = 2'($urandom_range(0, 3));
          rt  = 4'($urandom_range(0, 15));
          sel = int'($urandom_range(0, 3));
          if (sel == 0)      rs = '0;
          else if (sel == 1) rs = SW'(W - 1);
          else               rs = SW'($urandom_range(0, W - 1));
        end
        rr = ($urandom_range(0, 3) != 0);
      end
      @(posedge clock); #1;
      rv = 1'b0;
      rr = 1'b1;
      k = 0;
      while (q.size() != 0 && k < 200) begin
        @(negedge clock);
        k++;
      end
      check($sformatf("w%0d_drain_empty", W), q.size(), 0);
      rnd_done_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w;
    int k;
    d_rst_n = 1'b0; r_rst_n = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0; d_in_shamt = '0;
    d_in_op = 2'd0; d_in_tag = '0; d_out_ready = 1'b1;

    #12;
    check("rst_out_valid", d_out_valid, 1'b0);
    check("rst_out_data", d_out_data, 32'd0);
    check("rst_out_carry", d_out_carry, 1'b0);
    check("rst_out_zero", d_out_zero, 1'b0);
    check("rst_out_tag", d_out_tag, 4'd0);
    check("rst_in_ready", d_in_ready, 1'b1);

    @(negedge clock); #2;
    d_rst_n = 1'b1;

    // SLL 1 by 31, accepted on the first edge after release.
    d_send(2'd0, 32'h0000_0001, 5'd31, 4'h1, 32'h8000_0000, 1'b0, w);
    check("first_accept_wait", w, 0);
    d_latency();

    // SRA / SRL / ROL / carry-out vectors, back to back.
    d_send(2'd2, 32'h8000_0000, 5'd4, 4'h2, 32'hF800_0000, 1'b0, w);
    d_send(2'd1, 32'h8000_0000, 5'd4, 4'h3, 32'h0800_0000, 1'b0, w);
    d_send(2'd3, 32'h8000_0001, 5'd1, 4'h4, 32'h0000_0003, 1'b0, w);
    d_send(2'd0, 32'h8000_0000, 5'd1, 4'h5, 32'h0000_0000, 1'b1, w);
    d_send(2'd1, 32'h0000_0003, 5'd1, 4'h6, 32'h0000_0001, 1'b1, w);
    d_send(2'd2, 32'hA5A5_0F0F, 5'd0, 4'h7, 32'hA5A5_0F0F, 1'b0, w);
    d_idle();
    d_drain();

    // Tagged stream of 8 with the consumer stalled at the start.
    d_out_ready = 1'b0;
    d_accepts = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          d_send_m(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
        d_idle();
      end
      begin
        k = 0;
        while (d_accepts < 2 && k < 100) begin
          @(negedge clock);
          k++;
        end
        @(negedge clock);
        check("stall_in_ready", d_in_ready, 1'b0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        d_out_ready = 1'b1;
      end
    join
    d_drain();

    // Reset pulse with both stages occupied.
    d_out_ready = 1'b0;
    d_send_m(2'd0, 32'h1234_5678, 5'd3, 4'h9);
    d_send_m(2'd3, 32'hCAFE_F00D, 5'd17, 4'hA);
    d_idle();
    @(negedge clock);
    check("pre_reset_out_valid", d_out_valid, 1'b1);
    #2;
    d_rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", d_out_valid, 1'b0);
    check("async_reset_in_ready", d_in_ready, 1'b1);
    dq.delete();
    @(posedge clock);
    @(negedge clock); #2;
    d_rst_n = 1'b1;
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_stale_after_reset", d_out_valid, 1'b0);
    end
    d_send_m(2'd1, 32'hFFFF_0000, 5'd8, 4'hB);
    d_latency();
    d_drain();

    // Random regression on all three widths in parallel.
    @(negedge clock); #2;
    r_rst_n = 1'b1;
    run_rnd = 1'b1;
    k = 0;
    while (rnd_done_cnt < 3 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check("rnd_all_done", rnd_done_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_total++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the width of an opaque tag carried alongside each operation.
REQ-003 SHALL derive local SH_W = log2(WIDTH) and local LO_W = SH_W/2 (integer division); these are not overridable.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request presented.
REQ-007 in_ready  output  1  block accepts the request this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  SH_W  shift amount, 0..WIDTH-1.
REQ-010 in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
REQ-011 in_tag  input  TAG_W  passed through unchanged.
REQ-012 out_valid  output  1  result presented.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  WIDTH  shift result.
REQ-015 out_carry  output  1  last bit shifted out.
REQ-016 out_zero  output  1  out_data == 0.
REQ-017 out_tag  output  TAG_W  tag of this result.

Function
REQ-018 Transfer occurs on a rising edge where valid && ready, on both ports.
REQ-019 Two register stages, S1 and S2, each holding a valid bit plus its payload; S2 drives the out_* ports directly from registers.
REQ-020 S1 SHALL apply the shift for in_shamt[LO_W-1:0]; S2 SHALL apply the shift for shamt[SH_W-1:LO_W] to the S1 result.
REQ-021 Latency: a request accepted at edge N SHALL present out_valid at edge N+2 when out_ready is held high.
REQ-022 Stage advance: S2 loads when S1 is valid and (S2 is empty or out_ready); S1 loads when in_valid and (S1 is empty or S1 advances this cycle).
REQ-023 in_ready = !S1_valid || S2 advancing; purely combinational, with no dependency on in_valid.
REQ-024 With out_ready held high, throughput SHALL be one result per cycle, with no bubbles.
REQ-025 While out_valid && !out_ready, out_data, out_carry, out_zero and out_tag SHALL be held stable.
REQ-026 SLL SHALL zero-fill; SRL SHALL zero-fill; SRA SHALL fill with in_data[WIDTH-1] of the original operand through both stages; ROL SHALL wrap the bits shifted out of the MSB into the LSB.
REQ-027 out_carry for SLL with shamt n>0 SHALL be in_data[WIDTH-n]; for SRL/SRA with n>0 it SHALL be in_data[n-1]; for shamt 0 or ROL it SHALL be 0. It is computed in S1 and piped.
REQ-028 shamt 0 SHALL return in_data unchanged for every op.
REQ-029 out_zero SHALL be registered with out_data, not derived combinationally from it.
REQ-030 No request may be dropped or duplicated, and results SHALL leave in acceptance order.

Reset
REQ-031 While reset_n is low: S1_valid=0, S2_valid=0, out_valid=0, out_data=0, out_carry=0, out_zero=0, out_tag=0; in_ready is 1 after reset.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight requests immediately (asynchronously), with no result emitted after release.
REQ-033 The first request SHALL be accepted on the first rising edge with reset_n high.

Verification
REQ-034 WIDTH=32, SLL 0x0000_0001 by 31, out_ready=1 -> out_data 0x8000_0000, carry 0, zero 0, 2 cycles after acceptance.
REQ-035 SRA 0x8000_0000 by 4 -> 0xF800_0000, carry 0; SRL of the same operand -> 0x0800_0000; ROL 0x8000_0001 by 1 -> 0x0000_0003, carry 0.
REQ-036 SLL 0x8000_0000 by 1 -> out_data 0, zero 1, carry 1; SRL 0x0000_0003 by 1 -> 0x0000_0001, carry 1.
REQ-037 Back-to-back stream of 8 tagged ops with out_ready held low for cycles 3-6 -> in_ready falls after 2 accepts, output held stable, all 8 results delivered in order with correct tags, no loss.
REQ-038 reset_n pulsed low for 1 cycle with both stages valid -> out_valid is 0 immediately; no stale result appears after release; next request returns in 2 cycles.
REQ-039 Random regression at WIDTH 8, 32 and 64 with random valid/ready is checked against a reference model for all ops and shift amounts, including shamt 0 and WIDTH-1.
